// File: rtl/vga_sync_receiver.sv
`default_nettype none
// ============================================================================
//  Module      : vga_sync_receiver
//  Description : Samples VGA h_sync/v_sync/rgb on the pixel strobe, recovers
//                pixel coordinates, checks line/frame timing, reports lock.
//  Revision    : 1.0 - initial release
// ============================================================================
module vga_sync_receiver #(
    parameter int H_ACTIVE    = 640,
    parameter int H_FP        = 16,
    parameter int H_SYNC      = 96,
    parameter int H_BP        = 48,
    parameter int V_ACTIVE    = 480,
    parameter int V_FP        = 10,
    parameter int V_SYNC      = 2,
    parameter int V_BP        = 33,
    parameter bit SYNC_ACTIVE = 1'b0,
    parameter int LOCK_FRAMES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        pix_en,
    input  logic        h_sync,
    input  logic        v_sync,
    input  logic [11:0] rgb_in,
    output logic [9:0]  pix_x,
    output logic [9:0]  pix_y,
    output logic [11:0] pix_rgb,
    output logic        pix_valid,
    output logic        frame_start,
    output logic        locked,
    output logic        err_h,
    output logic        err_v,
    output logic [7:0]  err_count
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int H_START = H_SYNC + H_BP;
    localparam int V_START = V_SYNC + V_BP;
    localparam int H_TMO   = 2 * H_TOTAL - 1;
    localparam int TMO_W   = $clog2(H_TMO + 1);

    localparam logic [9:0]       CNT_MAX   = 10'h3FF;
    localparam logic [9:0]       H_LAST    = 10'(H_TOTAL - 1);
    localparam logic [9:0]       V_LAST    = 10'(V_TOTAL - 1);
    localparam logic [9:0]       H_SYNC_W  = 10'(H_SYNC);
    localparam logic [9:0]       V_SYNC_W  = 10'(V_SYNC);
    localparam logic [9:0]       H_BEGIN   = 10'(H_START);
    localparam logic [9:0]       H_END     = 10'(H_START + H_ACTIVE);
    localparam logic [9:0]       V_BEGIN   = 10'(V_START);
    localparam logic [9:0]       V_END     = 10'(V_START + V_ACTIVE);
    localparam logic [TMO_W-1:0] TMO_LAST  = TMO_W'(H_TMO);
    localparam logic [TMO_W-1:0] TMO_PRE   = TMO_W'(H_TMO - 1);
    localparam logic [3:0]       GOOD_LAST = 4'(LOCK_FRAMES - 1);

    localparam logic [1:0] ST_UNLOCKED = 2'd0;
    localparam logic [1:0] ST_TRACK    = 2'd1;
    localparam logic [1:0] ST_LOCKED   = 2'd2;

    logic [9:0]       h_cnt;
    logic [9:0]       v_cnt;
    logic [TMO_W-1:0] tmo_cnt;
    logic             h_prev;
    logic             v_prev;
    logic             h_seen;
    logic             v_seen;
    logic             v_pend;
    logic [1:0]       state;
    logic [1:0]       next_state;
    logic [3:0]       good_cnt;
    logic [3:0]       next_good;
    logic             is_locked;

    logic             s_h;
    logic             s_v;
    logic             h_lead;
    logic             h_trail;
    logic             v_lead;
    logic             v_trail;
    logic [9:0]       h_cur;
    logic [9:0]       v_inc;
    logic [9:0]       v_cur;
    logic [TMO_W-1:0] tmo_cur;
    logic             v_restart;
    logic             h_len_bad;
    logic             h_wid_bad;
    logic             h_tmo;
    logic             v_len_bad;
    logic             v_wid_bad;
    logic             v_mis;
    logic             h_err_now;
    logic             v_err_now;
    logic             err_any;
    logic             frame_edge;
    logic             active;
    logic             valid_now;

    assign s_h     = (h_sync == SYNC_ACTIVE);
    assign s_v     = (v_sync == SYNC_ACTIVE);
    assign h_lead  = s_h & ~h_prev;
    assign h_trail = ~s_h & h_prev;
    assign v_lead  = s_v & ~v_prev;
    assign v_trail = ~s_v & v_prev;

    // Count values belonging to the pixel being sampled right now
    assign h_cur     = h_lead ? 10'd0 : ((h_cnt == CNT_MAX) ? h_cnt : h_cnt + 10'd1);
    assign tmo_cur   = h_lead ? '0 : ((tmo_cnt == TMO_LAST) ? tmo_cnt : tmo_cnt + 1'b1);
    assign v_restart = h_lead & (v_lead | v_pend);
    assign v_inc     = (v_cnt == CNT_MAX) ? v_cnt : v_cnt + 10'd1;
    assign v_cur     = h_lead ? (v_restart ? 10'd0 : v_inc) : v_cnt;

    assign h_len_bad = h_lead & h_seen & (h_cnt != H_LAST);
    assign h_wid_bad = h_trail & (h_cur != H_SYNC_W);
    assign h_tmo     = ~h_lead & (tmo_cnt == TMO_PRE);
    // A vsync edge off the hsync edge is reported once here; the length check
    // only applies to edges aligned with a line start.
    assign v_len_bad = v_lead & h_lead & v_seen & (v_cnt != V_LAST);
    assign v_wid_bad = v_trail & (v_cur != V_SYNC_W);
    assign v_mis     = v_lead & ~h_lead;

    assign h_err_now  = pix_en & (h_len_bad | h_wid_bad | h_tmo);
    assign v_err_now  = pix_en & (v_len_bad | v_wid_bad | v_mis);
    assign err_any    = h_err_now | v_err_now;
    assign frame_edge = pix_en & v_lead;

    assign active = (h_cur >= H_BEGIN) & (h_cur < H_END) &
                    (v_cur >= V_BEGIN) & (v_cur < V_END);
    assign valid_now = pix_en & active & locked;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            h_cnt   <= '0;
            v_cnt   <= '0;
            tmo_cnt <= '0;
            h_prev  <= 1'b0;
            v_prev  <= 1'b0;
            h_seen  <= 1'b0;
            v_seen  <= 1'b0;
            v_pend  <= 1'b0;
        end else if (pix_en) begin
            h_prev  <= s_h;
            v_prev  <= s_v;
            h_cnt   <= h_cur;
            v_cnt   <= v_cur;
            tmo_cnt <= tmo_cur;
            if (h_lead) begin
                h_seen <= 1'b1;
            end
            if (v_lead) begin
                v_seen <= 1'b1;
            end
            if (v_lead & ~h_lead) begin
                v_pend <= 1'b1;
            end else if (h_lead) begin
                v_pend <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= ST_UNLOCKED;
            good_cnt <= '0;
        end else begin
            state    <= next_state;
            good_cnt <= next_good;
        end
    end

    always_comb begin
        next_state = state;
        next_good  = good_cnt;
        case (state)
            ST_UNLOCKED: begin
                if (frame_edge & ~err_any) begin
                    next_state = ST_TRACK;
                    next_good  = '0;
                end
            end
            ST_TRACK: begin
                if (err_any) begin
                    next_state = ST_UNLOCKED;
                    next_good  = '0;
                end else if (frame_edge) begin
                    if (good_cnt == GOOD_LAST) begin
                        next_state = ST_LOCKED;
                    end
                    next_good = good_cnt + 4'd1;
                end
            end
            ST_LOCKED: begin
                if (err_any) begin
                    next_state = ST_UNLOCKED;
                    next_good  = '0;
                end
            end
            default: begin
                next_state = ST_UNLOCKED;
                next_good  = '0;
            end
        endcase
    end

    always_comb begin
        is_locked = (state == ST_LOCKED);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pix_x       <= '0;
            pix_y       <= '0;
            pix_rgb     <= '0;
            pix_valid   <= 1'b0;
            frame_start <= 1'b0;
            locked      <= 1'b0;
            err_h       <= 1'b0;
            err_v       <= 1'b0;
            err_count   <= '0;
        end else begin
            pix_valid   <= valid_now;
            frame_start <= frame_edge;
            err_h       <= h_err_now;
            err_v       <= v_err_now;
            locked      <= is_locked;
            if (valid_now) begin
                pix_x   <= h_cur - H_BEGIN;
                pix_y   <= v_cur - V_BEGIN;
                pix_rgb <= rgb_in;
            end
            if (err_any && (err_count != 8'hFF)) begin
                err_count <= err_count + 8'd1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_vga_sync_receiver.sv
`default_nettype none
// ============================================================================
//  Module      : tb_vga_sync_receiver
//  Description : Directed self-checking bench for vga_sync_receiver using a
//                scaled-down 16x11 timing so whole frames stay short.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_vga_sync_receiver;

    localparam int H_ACTIVE = 8;
    localparam int H_FP     = 2;
    localparam int H_SYNC   = 3;
    localparam int H_BP     = 3;
    localparam int V_ACTIVE = 6;
    localparam int V_FP     = 1;
    localparam int V_SYNC   = 2;
    localparam int V_BP     = 2;
    localparam bit SA       = 1'b0;
    localparam int H_TOTAL  = 16;
    localparam int V_TOTAL  = 11;
    localparam int H_START  = 6;
    localparam int V_START  = 4;
    localparam int FRAME_PIX = H_ACTIVE * V_ACTIVE;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        pix_en = 1'b0;
    logic        h_sync = ~SA;
    logic        v_sync = ~SA;
    logic [11:0] rgb_in = '0;
    logic [9:0]  pix_x;
    logic [9:0]  pix_y;
    logic [11:0] pix_rgb;
    logic        pix_valid;
    logic        frame_start;
    logic        locked;
    logic        err_h;
    logic        err_v;
    logic [7:0]  err_count;

    int n_assert = 0;
    int n_fail   = 0;

    int cur_hc = 0;
    int cur_vc = 0;
    int mon_valid = 0;
    int mon_errh = 0;
    int mon_errv = 0;
    int mon_fs = 0;
    int rgb_bad = 0;
    int pos_bad = 0;
    int first_idx = -1;
    logic [9:0] first_x = '0;
    logic [9:0] first_y = '0;
    logic [9:0] last_x = '0;
    logic [9:0] last_y = '0;
    logic lock_at_err = 1'b0;
    logic lock_after_err = 1'b1;
    bit   chk_next = 1'b0;

    vga_sync_receiver #(
        .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
        .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
        .SYNC_ACTIVE(SA), .LOCK_FRAMES(2)
    ) dut (
        .clk(clk), .reset(reset), .pix_en(pix_en), .h_sync(h_sync),
        .v_sync(v_sync), .rgb_in(rgb_in), .pix_x(pix_x), .pix_y(pix_y),
        .pix_rgb(pix_rgb), .pix_valid(pix_valid), .frame_start(frame_start),
        .locked(locked), .err_h(err_h), .err_v(err_v), .err_count(err_count)
    );

    always #5 clk = ~clk;

    // Event monitor: counts pulses and checks each reported pixel against the
    // pixel driven on the strobe one clk earlier.
    always @(negedge clk) begin
        if (chk_next) begin
            lock_after_err = locked;
            chk_next = 1'b0;
        end
        if (pix_valid) begin
            if (mon_valid == first_idx) begin
                first_x = pix_x;
                first_y = pix_y;
            end
            last_x = pix_x;
            last_y = pix_y;
            if (pix_rgb !== {pix_x[3:0], pix_y[3:0], 4'h5}) rgb_bad++;
            if (int'(pix_x) != cur_hc - H_START || int'(pix_y) != cur_vc - V_START) pos_bad++;
            mon_valid++;
        end
        if (err_h) mon_errh++;
        if (err_v) mon_errv++;
        if (err_h || err_v) begin
            lock_at_err = locked;
            chk_next = 1'b1;
        end
        if (frame_start) mon_fs++;
    end

    // One pixel: strobe for one clk, then scramble inputs while pix_en is low.
    task automatic drive_pix(input int hc, input int vc, input bit hs, input bit vs);
        @(negedge clk);
        cur_hc = hc;
        cur_vc = vc;
        h_sync = hs ? SA : ~SA;
        v_sync = vs ? SA : ~SA;
        rgb_in = {4'(hc - H_START), 4'(vc - V_START), 4'h5};
        pix_en = 1'b1;
        @(negedge clk);
        pix_en = 1'b0;
        h_sync = ~h_sync;
        v_sync = ~v_sync;
        rgb_in = ~rgb_in;
    endtask

    task automatic drive_line(input int vc, input int len, input int sync_w,
                              input bit hmask, input bit vearly);
        for (int hc = 0; hc < len; hc++) begin
            drive_pix(hc, vc, !hmask && (hc < sync_w),
                      (vc < V_SYNC) || (vearly && hc >= 5));
        end
    endtask

    task automatic drive_lines(input int from_vc, input int to_vc);
        for (int vc = from_vc; vc <= to_vc; vc++) begin
            drive_line(vc, H_TOTAL, H_SYNC, 1'b0, 1'b0);
        end
    endtask

    task automatic drive_frame(input int short_vc, input int wide_vc);
        for (int vc = 0; vc < V_TOTAL; vc++) begin
            drive_line(vc, (vc == short_vc) ? H_TOTAL - 1 : H_TOTAL,
                       (vc == wide_vc) ? H_SYNC + 1 : H_SYNC, 1'b0, 1'b0);
        end
    endtask

    task automatic test_reset;
        reset = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        n_assert++;
        if ({pix_x, pix_y, pix_rgb, pix_valid, frame_start, locked, err_h, err_v, err_count} !== 45'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %h expected 0",
                     {pix_x, pix_y, pix_rgb, pix_valid, frame_start, locked, err_h, err_v, err_count});
        end
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_lock_acquire;
        int fs0;
        int v0;
        fs0 = mon_fs;
        v0  = mon_valid;
        drive_frame(-1, -1);
        drive_frame(-1, -1);
        n_assert++;
        if (locked !== 1'b0) begin n_fail++; $display("FAIL lock_early: locked=%b expected 0", locked); end
        n_assert++;
        if (mon_fs - fs0 != 2) begin n_fail++; $display("FAIL frame_start_count: got %0d expected 2", mon_fs - fs0); end
        n_assert++;
        if (mon_valid != v0) begin n_fail++; $display("FAIL valid_unlocked: got %0d expected 0", mon_valid - v0); end
        v0 = mon_valid;
        first_idx = mon_valid;
        drive_frame(-1, -1);
        n_assert++;
        if (locked !== 1'b1) begin n_fail++; $display("FAIL lock_third_edge: locked=%b expected 1", locked); end
        n_assert++;
        if (mon_valid - v0 != FRAME_PIX) begin n_fail++; $display("FAIL frame3_valid: got %0d expected %0d", mon_valid - v0, FRAME_PIX); end
        n_assert++;
        if (first_x !== 10'd0 || first_y !== 10'd0) begin n_fail++; $display("FAIL first_pixel: got (%0d,%0d) expected (0,0)", first_x, first_y); end
        n_assert++;
        if (last_x !== 10'(H_ACTIVE - 1) || last_y !== 10'(V_ACTIVE - 1)) begin
            n_fail++; $display("FAIL last_pixel: got (%0d,%0d) expected (%0d,%0d)", last_x, last_y, H_ACTIVE - 1, V_ACTIVE - 1);
        end
        n_assert++;
        if (err_count !== 8'd0) begin n_fail++; $display("FAIL nominal_err_count: got %0d expected 0", err_count); end
    endtask

    task automatic test_rgb_mapping;
        int v0;
        int r0;
        int p0;
        v0 = mon_valid; r0 = rgb_bad; p0 = pos_bad;
        drive_frame(-1, -1);
        n_assert++;
        if (mon_valid - v0 != FRAME_PIX) begin n_fail++; $display("FAIL rgb_frame_valid: got %0d expected %0d", mon_valid - v0, FRAME_PIX); end
        n_assert++;
        if (rgb_bad != r0) begin n_fail++; $display("FAIL rgb_match: got %0d bad pixels expected 0", rgb_bad - r0); end
        n_assert++;
        if (pos_bad != p0) begin n_fail++; $display("FAIL pixel_latency: got %0d misplaced pixels expected 0", pos_bad - p0); end
    endtask

    task automatic relock(input int exp_cnt);
        drive_frame(-1, -1);
        drive_frame(-1, -1);
        n_assert++;
        if (locked !== 1'b0) begin n_fail++; $display("FAIL relock_early: locked=%b expected 0", locked); end
        drive_frame(-1, -1);
        n_assert++;
        if (locked !== 1'b1) begin n_fail++; $display("FAIL relock: locked=%b expected 1", locked); end
        n_assert++;
        if (err_count !== 8'(exp_cnt)) begin n_fail++; $display("FAIL relock_err_count: got %0d expected %0d", err_count, exp_cnt); end
    endtask

    task automatic test_short_line;
        int h0;
        int e0;
        h0 = mon_errh; e0 = mon_errv;
        drive_frame(5, -1);
        n_assert++;
        if (mon_errh - h0 != 1) begin n_fail++; $display("FAIL short_err_h: got %0d expected 1", mon_errh - h0); end
        n_assert++;
        if (mon_errv != e0) begin n_fail++; $display("FAIL short_err_v: got %0d expected 0", mon_errv - e0); end
        n_assert++;
        if (lock_at_err !== 1'b1 || lock_after_err !== 1'b0) begin
            n_fail++; $display("FAIL short_lock_drop: got %b%b expected 10", lock_at_err, lock_after_err);
        end
        n_assert++;
        if (err_count !== 8'd1) begin n_fail++; $display("FAIL short_err_count: got %0d expected 1", err_count); end
        relock(1);
    endtask

    task automatic test_wide_sync;
        int h0;
        h0 = mon_errh;
        drive_frame(-1, 3);
        n_assert++;
        if (mon_errh - h0 != 1) begin n_fail++; $display("FAIL wide_err_h: got %0d expected 1", mon_errh - h0); end
        n_assert++;
        if (locked !== 1'b0 || lock_after_err !== 1'b0) begin
            n_fail++; $display("FAIL wide_unlock: got %b%b expected 00", locked, lock_after_err);
        end
        n_assert++;
        if (err_count !== 8'd2) begin n_fail++; $display("FAIL wide_err_count: got %0d expected 2", err_count); end
        relock(2);
    endtask

    task automatic test_timeout;
        int h0;
        int v0;
        drive_lines(0, 4);
        h0 = mon_errh; v0 = mon_valid;
        drive_line(5, H_TOTAL, H_SYNC, 1'b1, 1'b0);
        drive_line(6, H_TOTAL, H_SYNC, 1'b1, 1'b0);
        n_assert++;
        if (mon_errh - h0 != 1) begin n_fail++; $display("FAIL timeout_err_h: got %0d expected 1", mon_errh - h0); end
        n_assert++;
        if (mon_valid != v0) begin n_fail++; $display("FAIL timeout_valid: got %0d expected 0", mon_valid - v0); end
        n_assert++;
        if (locked !== 1'b0) begin n_fail++; $display("FAIL timeout_locked: locked=%b expected 0", locked); end
        n_assert++;
        if (err_count !== 8'd3) begin n_fail++; $display("FAIL timeout_err_count: got %0d expected 3", err_count); end
        drive_lines(7, V_TOTAL - 1);
        drive_frame(-1, -1);
    endtask

    task automatic test_reset_midframe;
        int h0;
        int e0;
        drive_lines(0, 6);
        @(negedge clk);
        reset = 1'b0;
        #1;
        n_assert++;
        if ({pix_x, pix_y, pix_rgb, pix_valid, frame_start, locked, err_h, err_v, err_count} !== 45'd0) begin
            n_fail++;
            $display("FAIL midframe_reset: got %h expected 0",
                     {pix_x, pix_y, pix_rgb, pix_valid, frame_start, locked, err_h, err_v, err_count});
        end
        repeat (2) @(negedge clk);
        reset = 1'b1;
        h0 = mon_errh; e0 = mon_errv;
        drive_lines(7, V_TOTAL - 1);
        relock(0);
        n_assert++;
        if (mon_errh != h0 || mon_errv != e0) begin
            n_fail++; $display("FAIL post_reset_errors: got %0d expected 0", (mon_errh - h0) + (mon_errv - e0));
        end
    endtask

    task automatic test_vsync_misaligned;
        int fs0;
        int e0;
        int h0;
        fs0 = mon_fs; e0 = mon_errv; h0 = mon_errh;
        drive_lines(0, V_TOTAL - 2);
        drive_line(V_TOTAL - 1, H_TOTAL, H_SYNC, 1'b0, 1'b1);
        drive_frame(-1, -1);
        n_assert++;
        if (mon_fs - fs0 != 2) begin n_fail++; $display("FAIL misaligned_frame_start: got %0d expected 2", mon_fs - fs0); end
        n_assert++;
        if (mon_errv - e0 != 1) begin n_fail++; $display("FAIL misaligned_err_v: got %0d expected 1", mon_errv - e0); end
        n_assert++;
        if (mon_errh != h0) begin n_fail++; $display("FAIL misaligned_err_h: got %0d expected 0", mon_errh - h0); end
        n_assert++;
        if (locked !== 1'b0 || err_count !== 8'd1) begin
            n_fail++; $display("FAIL misaligned_status: got locked=%b count=%0d expected locked=0 count=1", locked, err_count);
        end
        drive_frame(-1, -1);
        n_assert++;
        if (mon_errv - e0 != 1 || mon_fs - fs0 != 3) begin
            n_fail++; $display("FAIL misaligned_resync: got err_v=%0d fs=%0d expected err_v=1 fs=3", mon_errv - e0, mon_fs - fs0);
        end
    endtask

    initial begin
        test_reset();
        test_lock_acquire();
        test_rgb_mapping();
        test_short_line();
        test_wide_sync();
        test_timeout();
        test_reset_midframe();
        test_vsync_misaligned();
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/vga_sync_receiver.md
Name: vga_sync_receiver

Overview:
- Receive-side counterpart of the VGA timing generator. Samples h_sync, v_sync and 12-bit rgb on the pixel-rate strobe.
- Recovers pixel coordinates, checks line and frame timing against parameters, and reports lock status.
- Used as an on-chip loopback monitor of the display output, and as the front end of a frame-capture path.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, hsync pulse width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vsync pulse width (lines)
- V_BP, 33, vertical back porch (lines)
- SYNC_ACTIVE, 0, level of an asserted sync pulse (0 = active-low)
- LOCK_FRAMES, 2, consecutive good frames required to lock (1..15)

Ports:
- clk, input, 1, system clock (50 MHz)
- reset, input, 1, asynchronous active-low reset
- pix_en, input, 1, one-clk strobe at pixel rate; all sampling and counting happens only on pix_en cycles
- h_sync, input, 1, horizontal sync
- v_sync, input, 1, vertical sync
- rgb_in, input, 12, pixel colour
- pix_x, output, 10, recovered column 0..H_ACTIVE-1
- pix_y, output, 10, recovered row 0..V_ACTIVE-1
- pix_rgb, output, 12, registered rgb_in for the reported pixel
- pix_valid, output, 1, one-clk pulse per active pixel while locked
- frame_start, output, 1, one-clk pulse on each vsync leading edge
- locked, output, 1, timing lock status
- err_h, output, 1, one-clk pulse on a horizontal timing error
- err_v, output, 1, one-clk pulse on a vertical timing error
- err_count, output, 8, saturating count of err_h plus err_v events; cleared only by reset

Behaviour:
- Derived constants:
  - H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800)
  - V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (525)
  - H_START = H_SYNC+H_BP
  - V_START = V_SYNC+V_BP
- Reset (asynchronous, while reset=0): all outputs 0; h_cnt=0, v_cnt=0; h_prev and v_prev set to inactive; FSM=UNLOCKED; good-frame count 0. Reset mid-frame discards all state.
- On each pix_en cycle, sample s_h and s_v. Leading edge = sample active and prev inactive. Trailing edge = sample inactive and prev active. Then prev <= sample.
- Horizontal counting:
  - hsync leading edge: h_cnt <= 0, and this pixel is h_cnt 0.
  - Otherwise h_cnt increments, saturating at 1023.
  - hsync trailing edge: the current pixel's count must equal H_SYNC, else err_h.
  - At a leading edge, the previous h_cnt must equal H_TOTAL-1, else err_h. The first edge after reset is exempt.
  - Timeout: h_cnt reaching 2*H_TOTAL-1 without a leading edge raises err_h once.
- Vertical counting (on hsync leading edges only):
  - vsync leading edge (v sample active, v_prev inactive) on the same pix_en: v_cnt <= 0.
  - Otherwise v_cnt increments, saturating at 1023.
  - vsync trailing edge: v_cnt must equal V_SYNC, else err_v.
  - At a vsync leading edge, the previous v_cnt must equal V_TOTAL-1, else err_v. The first edge after reset is exempt.
- vsync leading edge not coincident with an hsync leading edge:
  - frame_start still pulses.
  - v_cnt resets at the next hsync leading edge.
  - err_v is raised once.
- Active area: H_START <= h_cnt < H_START+H_ACTIVE and V_START <= v_cnt < V_START+V_ACTIVE. In the active area, pix_x = h_cnt-H_START and pix_y = v_cnt-V_START (10-bit).
- Lock FSM:
  - UNLOCKED -> TRACK on a vsync leading edge; good count = 0.
  - TRACK: any err_h or err_v -> UNLOCKED. Each error-free vsync leading edge increments the good count; when it reaches LOCK_FRAMES -> LOCKED.
  - LOCKED: any err_h or err_v -> UNLOCKED in the same cycle the error pulses. locked is deasserted the following clk.
  - locked = 1 only in LOCKED.
- Output timing:
  - pix_valid, pix_x, pix_y, pix_rgb, frame_start, err_h and err_v are registered. They are asserted exactly 1 clk after the pix_en cycle that sampled the pixel or edge, and are 1 clk wide.
  - pix_x, pix_y and pix_rgb hold their last values when pix_valid=0.
  - pix_valid requires locked=1 at the sampling cycle.
- Error count: err_count adds 1 per cycle with err_h or err_v. When both occur in the same cycle it adds 1, not 2. It saturates at 255.
- pix_en=0: no state changes at all. Sync or rgb changes between strobes are ignored.

Test Plan:
- Reset, then nominal 640x480 timing from the team's vga_controller, pix_en every 2nd clk, 3 frames:
  - locked rises after the 3rd vsync leading edge (LOCK_FRAMES=2).
  - Frame 3 gives 307200 pix_valid pulses; the first is (0,0), the last is (639,479).
  - err_count = 0.
- Locked, rgb_in = {x[3:0], y[3:0], 4'h5}: every pix_valid has pix_rgb matching pix_x and pix_y, with 1-clk latency from the sampling strobe.
- Locked, one line shortened to 799 pixels: single err_h pulse; locked drops next clk; err_count = 1; relock after 2 further good frames.
- Locked, one hsync pulse widened to 97 pixels: err_h at the trailing edge; unlock.
- Hold h_sync inactive for 1600 pix_en cycles: exactly one err_h (timeout); locked = 0; no pix_valid.
- Assert reset mid-frame at line 200: all outputs 0 immediately. After release, the first vsync edge is exempt from the frame-length check and lock is regained after the required frames.
